// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity modes, transmitter FSM
// encoding and the parity-bit helper.
package uart_pkg;

   localparam int PAR_NONE      = 0;
   localparam int PAR_ODD       = 1;
   localparam int PAR_EVEN      = 2;
   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Data is zero-extended to MAX_DATA_BITS, so unused high bits never change the parity.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
      logic result;
      result = 1'b0;
      if (mode == PAR_ODD)
         result = ~(^data);
      else if (mode == PAR_EVEN)
         result = ^data;
      return result;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter running 0..CLKS_PER_BIT-1; bit_tick marks the last cycle of a bit.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt;

   assign bit_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clear)
         cnt <= '0;
      else if (bit_tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding register, allowing
// back-to-back frames with no idle gap between stop and start bits.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx_pin
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   tx_state_t            state;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_full;
   logic                 par_bit;
   logic [3:0]           bit_idx;
   logic                 bit_tick;
   logic                 baud_clear;
   logic                 accept;
   logic                 frame_end;

   assign baud_clear = (state == ST_IDLE);
   assign accept     = tx_start && !hold_full;
   assign frame_end  = (state == ST_STOP) && bit_tick && (bit_idx == LAST_STOP);
   assign tx_ready   = !hold_full;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (baud_clear),
      .bit_tick(bit_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         tx_pin    <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
         hold_full <= 1'b0;
         bit_idx   <= '0;
      end else begin
         tx_done <= 1'b0;

         // A start during a frame parks in the holding register, except at frame end where it goes straight to the line.
         if (accept && state != ST_IDLE && !frame_end) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shreg   <= tx_data;
                  par_bit <= parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
                  state   <= ST_START;
                  tx_pin  <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_tick) begin
                  state   <= ST_DATA;
                  bit_idx <= '0;
                  tx_pin  <= shreg[0];
                  shreg   <= shreg >> 1;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
                     if (PARITY != PAR_NONE) begin
                        state  <= ST_PARITY;
                        tx_pin <= par_bit;
                     end else begin
                        state  <= ST_STOP;
                        tx_pin <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     tx_pin  <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
            end
            ST_PARITY: begin
               if (bit_tick) begin
                  state  <= ST_STOP;
                  tx_pin <= 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_tick) begin
                  if (bit_idx != LAST_STOP) begin
                     bit_idx <= bit_idx + 4'd1;
                  end else begin
                     tx_done <= 1'b1;
                     bit_idx <= '0;
                     if (hold_full) begin
                        shreg     <= hold_data;
                        par_bit   <= parity_bit(MAX_DATA_BITS'(hold_data), PARITY);
                        hold_full <= 1'b0;
                        state     <= ST_START;
                        tx_pin    <= 1'b0;
                     end else if (tx_start) begin
                        shreg   <= tx_data;
                        par_bit <= parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
                        state   <= ST_START;
                        tx_pin  <= 1'b0;
                     end else begin
                        state   <= ST_IDLE;
                        tx_busy <= 1'b0;
                        tx_pin  <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               tx_pin  <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter variants driven in parallel,
// then back-to-back, overflow and mid-frame reset on the 8N1 instance.
module tb_uart_tx_param;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic [6:0] tx_data7 = 7'h00;
   logic [3:0] ready, busy, done, pin;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // u0: 8N1, u1: 8O1, u2: 8E1, u3: 7N2
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
      .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]), .tx_pin(pin[0]));
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
      .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]), .tx_pin(pin[1]));
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
      .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]), .tx_pin(pin[2]));
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data7), .tx_start(tx_start),
      .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done(done[3]), .tx_pin(pin[3]));

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected line level k cycles after the accepting edge; frame strings list bits in line order.
   function automatic logic exp_pin(input string f, input int k);
      int idx;
      idx = k / 4;
      if (idx < f.len())
         return (f[idx] == "1");
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   string fr[4];
   int    flen[4];

   initial begin
      fr[0] = "0010110011";  flen[0] = 40;
      fr[1] = "00101100111"; flen[1] = 44;
      fr[2] = "00101100101"; flen[2] = 44;
      fr[3] = "0101010111";  flen[3] = 40;

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      for (int u = 0; u < 4; u++) begin
         chk($sformatf("reset u%0d pin", u), pin[u], 1'b1);
         chk($sformatf("reset u%0d busy", u), busy[u], 1'b0);
         chk($sformatf("reset u%0d done", u), done[u], 1'b0);
         chk($sformatf("reset u%0d ready", u), ready[u], 1'b1);
      end
      rst_n = 1'b1;
      tick();

      // Single frame on all variants: 8'h9A on the 8-bit ones, 7'h55 on the 7N2 one
      tx_data  = 8'h9A;
      tx_data7 = 7'h55;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      for (int k = 0; k < 48; k++) begin
         for (int u = 0; u < 4; u++) begin
            chk($sformatf("single u%0d pin k=%0d", u, k), pin[u], exp_pin(fr[u], k));
            chk($sformatf("single u%0d busy k=%0d", u, k), busy[u], k < flen[u]);
            chk($sformatf("single u%0d done k=%0d", u, k), done[u], k == flen[u]);
            chk($sformatf("single u%0d ready k=%0d", u, k), ready[u], 1'b1);
         end
         tick();
      end

      // Back-to-back A5 then 3C, with an FF start while full that must be dropped
      tx_data  = 8'hA5;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      for (int k = 0; k < 86; k++) begin
         chk($sformatf("b2b pin k=%0d", k), pin[0], exp_pin("01010010110001111001", k));
         chk($sformatf("b2b busy k=%0d", k), busy[0], k < 80);
         chk($sformatf("b2b done k=%0d", k), done[0], k == 40 || k == 80);
         chk($sformatf("b2b ready k=%0d", k), ready[0], !(k >= 5 && k < 40));
         if (k == 4) begin
            tx_data  = 8'h3C;
            tx_start = 1'b1;
         end else if (k == 5) begin
            tx_data  = 8'hFF;
            tx_start = 1'b1;
         end else if (k == 6) begin
            tx_start = 1'b0;
         end
         tick();
      end

      // Reset during data bit 3 with 3C waiting in the holding register
      tx_data  = 8'h9A;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         chk($sformatf("abort pin k=%0d", k), pin[0], exp_pin(fr[0], k));
         if (k == 5) begin
            tx_data  = 8'h3C;
            tx_start = 1'b1;
         end else if (k == 6) begin
            tx_start = 1'b0;
         end
         if (k != 12)
            tick();
      end
      chk("abort held ready", ready[0], 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort pin", pin[0], 1'b1);
      chk("abort busy", busy[0], 1'b0);
      chk("abort ready", ready[0], 1'b1);
      chk("abort done", done[0], 1'b0);
      tick();
      for (int j = 0; j < 48; j++) begin
         chk($sformatf("after abort pin j=%0d", j), pin[0], 1'b1);
         chk($sformatf("after abort busy j=%0d", j), busy[0], 1'b0);
         chk($sformatf("after abort done j=%0d", j), done[0], 1'b0);
         tick();
      end

      // Clean frame after the abort
      tx_data  = 8'hA5;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      for (int k = 0; k < 42; k++) begin
         chk($sformatf("clean pin k=%0d", k), pin[0], exp_pin("0101001011", k));
         chk($sformatf("clean busy k=%0d", k), busy[0], k < 40);
         chk($sformatf("clean done k=%0d", k), done[0], k == 40);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
